interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-002 The block SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port `irq`, input, 8 bits: maskable request lines, rising-edge sensitive; bit 0 has highest priority.
REQ-004 The block SHALL have port `nmi_src`, input, 1 bit: non-maskable request line, rising-edge sensitive.
REQ-005 The block SHALL have port `mask_we`, input, 1 bit: write strobe for the mask register.
REQ-006 The block SHALL have port `mask_din`, input, 8 bits: new mask value; bit=1 disables the matching line.
REQ-007 The block SHALL have port `eoi`, input, 1 bit: end-of-interrupt pulse from the processor.
REQ-008 The block SHALL have port `INA`, input, 1 bit: interrupt acknowledge from the processor.
REQ-009 The block SHALL have port `INT`, output, 1 bit: maskable interrupt request to the processor.
REQ-010 The block SHALL have port `NMI`, output, 1 bit: non-maskable interrupt request to the processor.
REQ-011 The block SHALL have port `INTD`, output, 1 bit: high while a maskable interrupt is in service.
REQ-012 The block SHALL have port `int_vec`, output, 3 bits: index of the last acknowledged maskable line.
REQ-013 The block SHALL have port `timeout`, output, 1 bit: one-cycle pulse when an acknowledge timeout occurs.

Function
REQ-014 Edge detection: each line SHALL keep a registered copy of its previous value; a 0->1 transition SHALL set the matching pending bit (pend[7:0] for `irq`, nmi_pend for `nmi_src`).
REQ-015 If a set and a clear of the same pending bit occur in the same cycle, the set SHALL win.
REQ-016 `mask_we`=1 SHALL load `mask_din` into the mask register on the next edge; masking SHALL NOT clear pending bits.
REQ-017 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-018 IDLE -> REQ when any (pend & ~mask) bit is set; on entry the lowest such index SHALL be latched as sel.
REQ-019 `INT` SHALL be 1 exactly while in REQ, and SHALL be registered (no combinational path from `irq`).
REQ-020 REQ -> SERVICE on the first cycle with `INA`=1 and nmi_pend=0; on that same edge the block SHALL set `int_vec`<=sel, clear pend[sel] and set `INTD`<=1.
REQ-021 A mask change or a higher-priority request while in REQ SHALL NOT change sel.
REQ-022 SERVICE -> IDLE on `eoi`=1, clearing `INTD`; new requests SHALL only be pended while in SERVICE.
REQ-023 `eoi` outside SERVICE SHALL be ignored.
REQ-024 `NMI` SHALL equal nmi_pend, in any FSM state.
REQ-025 When `INA`=1 and nmi_pend=1, the acknowledge SHALL clear nmi_pend only; the FSM, sel and `int_vec` SHALL be unchanged.
REQ-026 NMI SHALL therefore take priority over INT when both are requesting.
REQ-027 Latency: an `irq` edge in IDLE at cycle n SHALL produce `INT`=1 at cycle n+2.
REQ-028 Latency: an `INA` acknowledge at cycle m SHALL produce `INT`=0 at cycle m+1.

Reset
REQ-029 While `rst`=1 the block SHALL set state=IDLE, pend=0, nmi_pend=0, mask=8'hFF, `INT`=0, `NMI`=0, `INTD`=0, `int_vec`=0 and `timeout`=0.
REQ-030 Reset SHALL load the edge-detect copies from the current inputs, so that lines already high at reset do not pend.
REQ-031 Reset asserted in REQ or SERVICE SHALL abort immediately; no acknowledge or eoi is required afterwards.

Configuration
REQ-032 With macro INTCTRL_ACK_TIMEOUT_EN defined, an 8-bit counter SHALL clear on REQ entry and increment each REQ cycle without `INA`.
REQ-033 With INTCTRL_ACK_TIMEOUT_EN defined, when the count reaches 255 the FSM SHALL return to IDLE, keep pend[sel] set and pulse `timeout` for one cycle.
REQ-034 With INTCTRL_ACK_TIMEOUT_EN defined, the re-arbitration after a timeout SHALL follow REQ-018.
REQ-035 Without INTCTRL_ACK_TIMEOUT_EN, REQ SHALL wait indefinitely for `INA`, `timeout` SHALL be tied to 0 and no counter SHALL be built.

Verification
REQ-036 The bench SHALL cover: reset; mask=0x00; pulse irq[5] -> INT=1 two cycles later; INA=1 -> int_vec=5, INTD=1, INT=0; eoi -> INTD=0, IDLE.
REQ-037 The bench SHALL cover: mask=0x00; irq[6] and irq[2] rise in the same cycle -> int_vec=2 after the first acknowledge; after eoi, INT re-asserts; second acknowledge -> int_vec=6.
REQ-038 The bench SHALL cover: INT pending for line 3 and an nmi_src edge -> NMI=1; INA clears NMI only, INT stays 1; second INA -> int_vec=3.
REQ-039 The bench SHALL cover: mask=0xFF; pulse irq[1] -> INT stays 0; write mask=0xFD -> INT=1, with the pending request preserved.
REQ-040 The bench SHALL cover: enter REQ, assert rst for one cycle -> all outputs 0, mask=0xFF, and no pending request survives.
REQ-041 The bench SHALL cover, with INTCTRL_ACK_TIMEOUT_EN defined: REQ held 255 cycles without INA -> timeout pulses once and INT drops, then INT re-asserts with the same int_vec after the acknowledge.

Source files
------------

// File: rtl/interrupt_controller.sv
// Priority interrupt controller: eight edge-triggered maskable lines plus one NMI.
// Optional acknowledge timeout is built when INTCTRL_ACK_TIMEOUT_EN is defined.
module interrupt_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq,
    input  logic       nmi_src,
    input  logic       mask_we,
    input  logic [7:0] mask_din,
    input  logic       eoi,
    input  logic       INA,
    output logic       INT,
    output logic       NMI,
    output logic       INTD,
    output logic [2:0] int_vec,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] irq_prev_q;
    logic       nmi_prev_q;
    logic [7:0] pend_q, pend_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic [7:0] mask_q;
    logic [2:0] sel_q, sel_d;
    logic [2:0] int_vec_q, int_vec_d;
    logic [7:0] irq_rise;
    logic       nmi_rise;
    logic [7:0] req_vec;
    logic [2:0] req_idx;
    logic [7:0] pend_clr;
    logic       nmi_clr;

    for (genvar gi = 0; gi < 8; gi++) begin : g_edge
        assign irq_rise[gi] = irq[gi] & ~irq_prev_q[gi];
    end
    assign nmi_rise = nmi_src & ~nmi_prev_q;
    assign req_vec  = pend_q & ~mask_q;

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        req_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_vec[i]) begin
                req_idx = 3'(i);
            end
        end
    end

`ifdef INTCTRL_ACK_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        int_vec_d = int_vec_q;
        pend_clr  = '0;
        nmi_clr   = INA & nmi_pend_q;
`ifdef INTCTRL_ACK_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    state_d = REQ;
                    sel_d   = req_idx;
`ifdef INTCTRL_ACK_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            REQ: begin
                // A pending NMI absorbs the acknowledge; the maskable request waits.
                if (INA && !nmi_pend_q) begin
                    state_d   = SERVICE;
                    int_vec_d = sel_q;
                    pend_clr  = 8'd1 << sel_q;
                end
`ifdef INTCTRL_ACK_TIMEOUT_EN
                else if (!INA) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd254) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
`endif
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d     = (pend_q & ~pend_clr) | irq_rise;
        nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            irq_prev_q <= irq;
            nmi_prev_q <= nmi_src;
            pend_q     <= '0;
            nmi_pend_q <= 1'b0;
            mask_q     <= 8'hFF;
            sel_q      <= 3'd0;
            int_vec_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq;
            nmi_prev_q <= nmi_src;
            pend_q     <= pend_d;
            nmi_pend_q <= nmi_pend_d;
            if (mask_we) begin
                mask_q <= mask_din;
            end
            sel_q      <= sel_d;
            int_vec_q  <= int_vec_d;
        end
    end

`ifdef INTCTRL_ACK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign INT     = (state_q == REQ);
    assign INTD    = (state_q == SERVICE);
    assign NMI     = nmi_pend_q;
    assign int_vec = int_vec_q;

endmodule
